// File: rtl/nes_clk_sequencer.sv
// Master-clock sequencer for the NES core: qualifies PLL lock, holds the core in reset,
// then derives phase-aligned CPU/PPU clock enables and the M2 level, with pause/single-step.
module nes_clk_sequencer #(
    parameter int CPU_DIV     = 12,
    parameter int PPU_DIV     = 4,
    parameter int M2_RISE     = 5,
    parameter int LOCK_HOLD   = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic pause,
    input  logic step,
    output logic sys_rst,
    output logic cpu_ce,
    output logic ppu_ce,
    output logic m2,
    output logic paused
);

    localparam int CNT_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPU_DIV - 1);
    localparam logic [CNT_W-1:0]  M2_AT     = CNT_W'(M2_RISE);
    localparam logic [CNT_W-1:0]  PPU_MOD   = CNT_W'(PPU_DIV);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_PAUSED,
        S_STEP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   run_d;

    logic sys_rst_q, cpu_ce_q, ppu_ce_q, m2_q, paused_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;

        unique case (state_q)
            S_WAIT_LOCK: begin
                cnt_d  = '0;
                hold_d = '0;
                if (locked_s) state_d = S_STABILIZE;
            end

            S_STABILIZE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            // A step cycle behaves exactly like a run cycle; only the entry path differs.
            S_RUN, S_STEP: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = pause ? S_PAUSED : S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PAUSED: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    hold_d  = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end

            default: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign run_d = (state_d == S_RUN) || (state_d == S_STEP);

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            hold_q    <= '0;
            sync_q    <= '0;
            sys_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            ppu_ce_q  <= 1'b0;
            m2_q      <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            sys_rst_q <= !(run_d || (state_d == S_PAUSED));
            cpu_ce_q  <= run_d && (cnt_d == '0);
            ppu_ce_q  <= run_d && ((cnt_d % PPU_MOD) == '0);
            m2_q      <= run_d && (cnt_d >= M2_AT);
            paused_q  <= (state_d == S_PAUSED);
        end
    end

    assign sys_rst = sys_rst_q;
    assign cpu_ce  = cpu_ce_q;
    assign ppu_ce  = ppu_ce_q;
    assign m2      = m2_q;
    assign paused  = paused_q;

endmodule

// File: tb/tb_nes_clk_sequencer.sv
// Self-checking bench for nes_clk_sequencer: directed scenarios plus random traffic,
// compared every cycle against a cycle-position model of the sequencer.
module tb_nes_clk_sequencer;

    localparam int CPU_DIV     = 12;
    localparam int PPU_DIV     = 4;
    localparam int M2_RISE     = 5;
    localparam int LOCK_HOLD   = 16;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic pause = 1'b0;
    logic step = 1'b0;
    logic sys_rst, cpu_ce, ppu_ce, m2, paused;
    logic [4:0] dut_vec;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nes_clk_sequencer #(
        .CPU_DIV(CPU_DIV), .PPU_DIV(PPU_DIV), .M2_RISE(M2_RISE),
        .LOCK_HOLD(LOCK_HOLD), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .pause(pause), .step(step),
        .sys_rst(sys_rst), .cpu_ce(cpu_ce), .ppu_ce(ppu_ce), .m2(m2), .paused(paused)
    );

    assign dut_vec = {sys_rst, cpu_ce, ppu_ce, m2, paused};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: lock history, length of the current unbroken locked streak, and position
    // within the current CPU cycle. Released once the streak exceeds LOCK_HOLD samples.
    typedef struct packed {
        logic       valid;
        logic [7:0] lhist;
        int         streak;
        int         phase;
        logic       halted;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t cur, logic r, logic lk, logic pz, logic st);
        model_t nxt;
        logic   ls;
        logic   was_released;
        nxt = cur;
        if (r) begin
            nxt = '0;
            nxt.valid = 1'b1;
            return nxt;
        end
        ls           = cur.lhist[SYNC_STAGES-1];
        nxt.lhist    = {cur.lhist[6:0], lk};
        was_released = cur.streak > LOCK_HOLD;
        if (!ls) begin
            nxt.streak = 0;
            nxt.phase  = 0;
            nxt.halted = 1'b0;
        end else begin
            nxt.streak = was_released ? cur.streak : cur.streak + 1;
            if (!was_released) begin
                nxt.phase  = 0;
                nxt.halted = 1'b0;
            end else if (cur.halted) begin
                if (!pz || st) begin
                    nxt.halted = 1'b0;
                    nxt.phase  = 0;
                end
            end else if (cur.phase == CPU_DIV - 1) begin
                nxt.phase  = 0;
                nxt.halted = pz;
            end else begin
                nxt.phase = cur.phase + 1;
            end
        end
        return nxt;
    endfunction

    function automatic logic [4:0] model_out(model_t cur);
        logic rel, run;
        rel = cur.streak > LOCK_HOLD;
        run = rel && !cur.halted;
        return {!rel, run && (cur.phase == 0), run && ((cur.phase % PPU_DIV) == 0),
                run && (cur.phase >= M2_RISE), rel && cur.halted};
    endfunction

    always @(posedge clk) m <= model_next(m, rst, pll_locked, pause, step);

    always @(negedge clk) begin
        if (m.valid) check("cycle", 32'(dut_vec), 32'(model_out(m)));
    end

    task automatic measure_release(output int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sys_rst !== 1'b0 && n < 200);
        lat = n - 1;
    endtask

    task automatic wait_paused(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (paused !== 1'b1 && n < 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, cpu_n, ppu_n, m2_n, gap_bad, last_ppu, rise_at, en;
        logic m2_prev;

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_vec), 32'(5'b10000));
        rst = 1'b0;

        // Lock acquisition: 2 sync stages + LOCK_HOLD hold cycles.
        pll_locked = 1'b1;
        measure_release(lat);
        check("release_latency", 32'(lat), 32'd18);
        check("first_run_cycle", 32'({cpu_ce, ppu_ce, m2}), 32'(3'b110));

        // 48 clocks of RUN: 4 CPU cycles.
        cpu_n = 0; ppu_n = 0; m2_n = 0; gap_bad = 0; last_ppu = -1; rise_at = -1; m2_prev = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cpu_n += int'(cpu_ce);
            m2_n  += int'(m2);
            if (ppu_ce) begin
                ppu_n++;
                if (last_ppu >= 0 && i - last_ppu != PPU_DIV) gap_bad++;
                last_ppu = i;
            end
            if (m2 && !m2_prev && rise_at < 0) rise_at = i;
            m2_prev = m2;
            @(negedge clk);
        end
        check("run_cpu_ce_count", 32'(cpu_n), 32'd4);
        check("run_ppu_ce_count", 32'(ppu_n), 32'd12);
        check("run_ppu_spacing", 32'(gap_bad), 32'd0);
        check("run_m2_high_count", 32'(m2_n), 32'd28);
        check("run_m2_rise_cnt", 32'(rise_at), 32'd5);

        // Lock glitch while hold == 10 restarts the hold count.
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        pll_locked = 1'b1;
        repeat (11) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        measure_release(lat);
        check("release_after_glitch", 32'(lat), 32'd18);

        // Pause requested mid CPU cycle (cnt == 3).
        repeat (3) @(negedge clk);
        pause = 1'b1;
        n = 0; cpu_n = 0;
        do begin
            @(negedge clk);
            n++;
            cpu_n += int'(cpu_ce);
        end while (paused !== 1'b1 && n < 50);
        check("pause_entry_delay", 32'(n), 32'd9);
        check("pause_no_new_cycle", 32'(cpu_n), 32'd0);
        en = 0;
        repeat (5) begin
            @(negedge clk);
            en += int'(cpu_ce | ppu_ce | m2);
        end
        check("paused_quiet", 32'(en), 32'd0);
        pause = 1'b0;
        @(negedge clk);
        check("resume_cpu_ce", 32'({cpu_ce, paused}), 32'(2'b10));

        // Single step from PAUSED.
        pause = 1'b1;
        wait_paused(n);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cpu_n = int'(cpu_ce); ppu_n = int'(ppu_ce);
        repeat (15) begin
            @(negedge clk);
            cpu_n += int'(cpu_ce);
            ppu_n += int'(ppu_ce);
        end
        check("step_cpu_ce", 32'(cpu_n), 32'd1);
        check("step_ppu_ce", 32'(ppu_n), 32'd3);
        check("step_repaused", 32'(paused), 32'd1);

        // Extra step pulses inside STEP are ignored.
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cpu_n = int'(cpu_ce); ppu_n = int'(ppu_ce);
        for (int i = 1; i < 24; i++) begin
            step = (i == 2 || i == 5);
            @(negedge clk);
            cpu_n += int'(cpu_ce);
            ppu_n += int'(ppu_ce);
        end
        step = 1'b0;
        check("dbl_step_cpu_ce", 32'(cpu_n), 32'd1);
        check("dbl_step_ppu_ce", 32'(ppu_n), 32'd3);

        // Lock loss at cnt == 7 in RUN.
        pause = 1'b0;
        @(negedge clk);
        repeat (7) @(negedge clk);
        pll_locked = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sys_rst !== 1'b1 && n < 20);
        check("lockloss_latency", 32'(n), 32'd3);
        check("lockloss_outputs", 32'(dut_vec), 32'(5'b10000));
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        measure_release(lat);
        check("relock_latency", 32'(lat), 32'd18);

        // rst in the middle of STEP.
        pause = 1'b1;
        wait_paused(n);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_step", 32'(dut_vec), 32'(5'b10000));
        rst = 1'b0;
        pause = 1'b0;

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) == 0);
            if (pll_locked) pll_locked = ($urandom_range(0, 299) != 0);
            else            pll_locked = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) pause = !pause;
            step = ($urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
